fft_peak_detector: RTL and testbench
====================================

// Module: fft_peak_detector
// PURPOSE
//  Downstream of fft_top_pipelined: consumes its data_out_valid/real/imag stream (one FFT frame =
//  FFT_POINTS bins, bin 0 first) and finds the strongest bin per frame. Magnitude is approximated
//  as max(|re|,|im|) + min(|re|,|im|)/2. Per frame it reports the peak bin index and magnitude to
//  the board-level controller over a valid/ack handshake (drives LEDs/GPIO on the IceStick).
// PARAMETERS
//  DATA_WIDTH  16  signed two's-complement width of in_real/in_imag
//  FFT_POINTS  64  bins per frame; power of two, equal to 2**ADDR_WIDTH
//  ADDR_WIDTH  6   bin index width
//  SKIP_DC     1   1: bin 0 is never a peak candidate; 0: bin 0 competes
// PORTS
//  clk        in   1             system clock, all logic on posedge
//  rst        in   1             synchronous reset, active-high
//  clear      in   1             sync abort: discard partial frame and pipeline contents
//  in_valid   in   1             input bin valid (FFT data_out_valid)
//  in_real    in   DATA_WIDTH    bin real part, signed
//  in_imag    in   DATA_WIDTH    bin imag part, signed
//  peak_valid out  1             result held valid until acked
//  peak_ack   in   1             consumer accepts result (valid & ack)
//  peak_bin   out  ADDR_WIDTH    index of strongest bin
//  peak_mag   out  DATA_WIDTH+1  unsigned approx magnitude of that bin
//  busy       out  1             frame partially received or pipeline non-empty
//  overrun    out  1             sticky: a result was overwritten before being acked
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all outputs 0, bin counter 0, pipeline valids 0, best=0.
//  - Bin counter: +1 per in_valid, wraps FFT_POINTS-1 -> 0; sample with count==FFT_POINTS-1 tagged last.
//    in_valid gaps allowed anywhere; back-to-back frames with no idle cycle are supported.
//  - Pipeline, 3 stages, each carrying valid/bin/last:
//    S1: |re|,|im|; -2^(DATA_WIDTH-1) saturates to 2^(DATA_WIDTH-1)-1.
//    S2: mag = max + (min>>1), DATA_WIDTH+1 bits unsigned, no overflow possible.
//    S3: compare vs running best; update only if mag > best_mag (strict: ties keep lower bin).
//        Bin 0 skipped when SKIP_DC=1. Frame-start best: mag 0, bin SKIP_DC.
//  - Latency: sample with in_valid at posedge N (last) -> peak_valid=1 after posedge N+3.
//  - On S3 last: peak_bin/peak_mag load final best (including the last bin itself), peak_valid<=1,
//    best reinitialised the same cycle, so the next frame's bin 0 in S3 next cycle is handled.
//  - Handshake: peak_valid/bin/mag stable while peak_valid & !peak_ack; cleared the cycle after ack.
//    New result with peak_valid=1 and no ack that cycle: outputs overwritten, overrun<=1.
//    New result and ack same cycle: new result loads, peak_valid stays 1, no overrun.
//  - overrun clears only on rst.
//  - clear: counter<=0, pipeline valids<=0, best reinit; peak_* and overrun untouched;
//    in_valid in the clear cycle is dropped. clear has priority over in_valid, below rst.
//  - busy = (counter!=0) | any pipeline valid.
// TESTING
//  1 Frame of 64 zeros except bin 5 = (1000,-2000), SKIP_DC=1 -> peak_bin=5, peak_mag=2500,
//    peak_valid 3 cycles after last in_valid.
//  2 Bin 0=(30000,0), bin 9=(100,100) -> SKIP_DC=1: bin 9, mag 150; SKIP_DC=0: bin 0, mag 30000.
//  3 Bins 3 and 40 both (-32768,-32768) -> bin 3, mag 49150 (saturation + tie rule).
//  4 Two back-to-back frames, no ack -> overrun=1, outputs show frame 2; ack -> peak_valid 0 next cycle.
//  5 clear after 20 bins, then full frame peaking at bin 12 -> bin 12; busy=0 the cycle after clear.
//  6 rst asserted mid-frame and with peak_valid=1 -> all outputs 0; random gapped in_valid frames
//    checked against reference model.

Source files
------------

// File: rtl/fft_peak_detector.sv
// fft_peak_detector: per-frame strongest-bin finder over an FFT output stream with valid/ack result handshake
module fft_peak_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_POINTS = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int SKIP_DC    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  output logic                         peak_valid,
  input  logic                         peak_ack,
  output logic [ADDR_WIDTH-1:0]        peak_bin,
  output logic [DATA_WIDTH:0]          peak_mag,
  output logic                         busy,
  output logic                         overrun
);
  localparam logic [ADDR_WIDTH-1:0] last_idx = ADDR_WIDTH'(FFT_POINTS - 1);
  localparam logic [ADDR_WIDTH-1:0] init_bin = ADDR_WIDTH'(SKIP_DC != 0);
  function automatic logic [DATA_WIDTH-2:0] sat_abs(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] n;
    n = -x;
    return (x == {1'b1, {(DATA_WIDTH-1){1'b0}}}) ? '1 : x[DATA_WIDTH-1] ? n[DATA_WIDTH-2:0] : x[DATA_WIDTH-2:0];
  endfunction
  logic [ADDR_WIDTH-1:0] cnt, s1_b, s2_b, s3_b, best_bin, fin_bin;
  logic                  s1_v, s2_v, s3_v, s1_l, s2_l, s3_l, cand, load;
  logic [DATA_WIDTH-2:0] s1_re, s1_im, mx, mn;
  logic [DATA_WIDTH:0]   mag_c, s2_mag, s3_mag, best_mag, fin_mag;
  always_comb begin
    mx      = s1_re > s1_im ? s1_re : s1_im;
    mn      = s1_re > s1_im ? s1_im : s1_re;
    mag_c   = (DATA_WIDTH+1)'(mx) + (DATA_WIDTH+1)'(mn >> 1);
    cand    = s3_v && !(SKIP_DC != 0 && s3_b == '0) && s3_mag > best_mag;
    fin_bin = cand ? s3_b : best_bin;
    fin_mag = cand ? s3_mag : best_mag;
    load    = s3_v && s3_l && !clear;
    busy    = (cnt != '0) | s1_v | s2_v | s3_v;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      {s1_v, s2_v, s3_v, s1_l, s2_l, s3_l} <= '0;
      {s1_b, s2_b, s3_b} <= '0;
      {s1_re, s1_im, s2_mag, s3_mag} <= '0;
      best_bin   <= init_bin;
      best_mag   <= '0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      overrun    <= 1'b0;
    end else begin
      cnt    <= clear ? '0 : in_valid ? cnt + 1'b1 : cnt;
      s1_v   <= in_valid && !clear;
      s1_b   <= cnt;
      s1_l   <= cnt == last_idx;
      s1_re  <= sat_abs(in_real);
      s1_im  <= sat_abs(in_imag);
      s2_v   <= s1_v && !clear;
      s2_b   <= s1_b;
      s2_l   <= s1_l;
      s2_mag <= mag_c;
      s3_v   <= s2_v && !clear;
      s3_b   <= s2_b;
      s3_l   <= s2_l;
      s3_mag <= s2_mag;
      // reinit on the last bin so a back-to-back frame's bin 0 starts fresh next cycle
      if (clear || (s3_v && s3_l)) begin
        best_bin <= init_bin;
        best_mag <= '0;
      end else if (cand) begin
        best_bin <= s3_b;
        best_mag <= s3_mag;
      end
      if (load) begin
        peak_valid <= 1'b1;
        peak_bin   <= fin_bin;
        peak_mag   <= fin_mag;
        overrun    <= overrun | (peak_valid & ~peak_ack);
      end else if (peak_ack) begin
        peak_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fft_peak_detector.sv
// tb_fft_peak_detector: directed and random-gap frames checked against a frame-level reference model
module tb_fft_peak_detector;
  localparam int SKIP = 1;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, peak_ack = 0;
  logic signed [15:0] in_real = 0, in_imag = 0;
  logic peak_valid, busy, overrun, pv0, busy0, ov0;
  logic [5:0] peak_bin, bin0;
  logic [16:0] peak_mag, mag0;
  fft_peak_detector #(.SKIP_DC(1)) dut (.clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag), .peak_valid(peak_valid), .peak_ack(peak_ack),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .busy(busy), .overrun(overrun));
  fft_peak_detector #(.SKIP_DC(0)) dut_dc (.clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag), .peak_valid(pv0), .peak_ack(peak_ack),
    .peak_bin(bin0), .peak_mag(mag0), .busy(busy0), .overrun(ov0));
  always #5 clk = ~clk;
  int vecs = 0, errs = 0, cyc = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  typedef struct {int due; int bin; int mag;} res_t;
  res_t q[$];
  res_t r;
  int m_cnt, fb_bin, fb_mag, m_bin, m_mag, last_acc, a, b, mg;
  bit m_pv, m_ov, m_busy;
  function automatic int sabs(input int x);
    return x < 0 ? (-x > 32767 ? 32767 : -x) : x;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_cnt = 0; fb_bin = SKIP; fb_mag = 0; q.delete();
      m_pv = 0; m_bin = 0; m_mag = 0; m_ov = 0; last_acc = -100;
    end else begin
      if (!clear && q.size() > 0 && q[0].due == cyc) begin
        if (m_pv && !peak_ack) m_ov = 1;
        m_pv = 1; m_bin = q[0].bin; m_mag = q[0].mag;
        void'(q.pop_front());
      end else if (peak_ack) m_pv = 0;
      if (clear) begin
        m_cnt = 0; fb_bin = SKIP; fb_mag = 0; q.delete(); last_acc = -100;
      end else if (in_valid) begin
        a = sabs(int'(in_real));
        b = sabs(int'(in_imag));
        mg = (a > b ? a : b) + (a > b ? b : a) / 2;
        if (!(SKIP == 1 && m_cnt == 0) && mg > fb_mag) begin fb_mag = mg; fb_bin = m_cnt; end
        last_acc = cyc;
        if (m_cnt == 63) begin
          r.due = cyc + 3; r.bin = fb_bin; r.mag = fb_mag;
          q.push_back(r);
          fb_bin = SKIP; fb_mag = 0;
        end
        m_cnt = (m_cnt + 1) % 64;
      end
    end
    m_busy = m_cnt != 0 || cyc - last_acc <= 2;
  end
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("peak_valid", 32'(peak_valid), 32'(m_pv));
      chk("overrun", 32'(overrun), 32'(m_ov));
      chk("busy", 32'(busy), 32'(m_busy));
      if (m_pv) begin
        chk("peak_bin", 32'(peak_bin), m_bin);
        chk("peak_mag", 32'(peak_mag), m_mag);
      end
    end
  end
  int fr_re[64], fr_im[64];
  bit gaps = 0, rnd_ack = 0;
  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic zero_frame();
    for (int i = 0; i < 64; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
  endtask
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_real = 16'(fr_re[i]); in_imag = 16'(fr_im[i]);
      if (rnd_ack) peak_ack = ($urandom % 4) == 0;
      tick();
      if (gaps && ($urandom % 3) == 0) begin
        in_valid = 0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    in_valid = 0;
  endtask
  task automatic ack();
    peak_ack = 1; tick(); peak_ack = 0;
    chk("ack_clears_valid", 32'(peak_valid), 0);
  endtask
  initial begin
    tick(); tick();
    chk("rst_valid", 32'(peak_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;
    zero_frame(); fr_re[5] = 1000; fr_im[5] = -2000;
    send(64); tick(); tick();
    chk("t1_not_yet", 32'(peak_valid), 0);
    tick();
    chk("t1_valid", 32'(peak_valid), 1);
    chk("t1_bin", 32'(peak_bin), 5);
    chk("t1_mag", 32'(peak_mag), 2500);
    ack();
    zero_frame(); fr_re[0] = 30000; fr_re[9] = 100; fr_im[9] = 100;
    send(64); repeat (3) tick();
    chk("t2_bin_skip", 32'(peak_bin), 9);
    chk("t2_mag_skip", 32'(peak_mag), 150);
    chk("t2_bin_dc", 32'(bin0), 0);
    chk("t2_mag_dc", 32'(mag0), 30000);
    ack();
    zero_frame(); fr_re[3] = -32768; fr_im[3] = -32768; fr_re[40] = -32768; fr_im[40] = -32768;
    send(64); repeat (3) tick();
    chk("t3_bin", 32'(peak_bin), 3);
    chk("t3_mag", 32'(peak_mag), 49150);
    ack();
    zero_frame(); fr_re[7] = 500;
    send(64);
    zero_frame(); fr_im[20] = -800;
    send(64); repeat (3) tick();
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_bin", 32'(peak_bin), 20);
    chk("t4_mag", 32'(peak_mag), 800);
    ack();
    zero_frame(); fr_re[3] = 9000;
    send(20);
    clear = 1; in_valid = 1; tick(); clear = 0; in_valid = 0;
    chk("t5_busy_after_clear", 32'(busy), 0);
    zero_frame(); fr_im[12] = 3000;
    send(64); repeat (3) tick();
    chk("t5_bin", 32'(peak_bin), 12);
    chk("t5_mag", 32'(peak_mag), 3000);
    zero_frame(); fr_re[33] = -7; fr_im[33] = 4;
    send(64); repeat (3) tick();
    chk("t6_pre_mag", 32'(peak_mag), 9);
    send(10);
    rst = 1; tick(); rst = 0;
    chk("t6_valid", 32'(peak_valid), 0);
    chk("t6_bin", 32'(peak_bin), 0);
    chk("t6_mag", 32'(peak_mag), 0);
    chk("t6_overrun", 32'(overrun), 0);
    chk("t6_busy", 32'(busy), 0);
    gaps = 1; rnd_ack = 1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 64; i++) begin
        fr_re[i] = int'($urandom_range(0, 65535)) - 32768;
        fr_im[i] = ($urandom % 8 == 0) ? -32768 : int'($urandom_range(0, 2000)) - 1000;
      end
      if (f == 2) begin
        send(15);
        clear = 1; tick(); clear = 0;
      end
      send(64);
    end
    repeat (8) begin peak_ack = ($urandom % 2) == 0; tick(); end
    peak_ack = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
